// File: rtl/api_sync_fifo_pkg.sv
// Shared sizing constants for the API-side FIFOs.
// api_ctrl sizes its RX space checks from API_FIFO_DEPTH and API_FIFO_CNT_W.
package api_sync_fifo_pkg;

    localparam int API_FIFO_DEPTH   = 512;
    localparam int API_FIFO_ADDR_W  = 9;
    localparam int API_FIFO_CNT_W   = API_FIFO_ADDR_W + 1;
    localparam int API_FIFO_DATA_W  = 32;
    localparam int API_FIFO_AFULL   = 480;

endpackage

// File: rtl/api_fifo_ram.sv
// Simple dual-port RAM for the API FIFO: synchronous write, registered read with enable.
// Only the read register is reset; the array itself is never cleared, so it maps to block RAM.
module api_fifo_ram
    import api_sync_fifo_pkg::*;
#(
    parameter int DATA_W = API_FIFO_DATA_W,
    parameter int DEPTH  = API_FIFO_DEPTH,
    parameter int ADDR_W = API_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/api_sync_fifo.sv
// Single-clock FIFO with occupancy count, registered level flags and sticky error flags.
// Used as both the TX (work) and RX (nonce) buffer beside the API block.
module api_sync_fifo
    import api_sync_fifo_pkg::*;
#(
    parameter int DATA_W    = API_FIFO_DATA_W,
    parameter int DEPTH     = API_FIFO_DEPTH,
    parameter int ADDR_W    = API_FIFO_ADDR_W,
    parameter int CNT_W     = API_FIFO_CNT_W,
    parameter int AFULL_THR = API_FIFO_AFULL
) (
    input  logic              CLK_I,
    input  logic              RST_N_I,
    input  logic              srst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [CNT_W-1:0]  data_count,
    output logic              overflow,
    output logic              underflow
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_nxt;

    // Accept decisions use the registered flags only, so no input reaches an output combinationally.
    assign push      = wr_en & ~full;
    assign pop       = rd_en & ~empty;
    assign count_nxt = data_count + CNT_W'(push) - CNT_W'(pop);

    api_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (CLK_I),
        .rst_n   (RST_N_I),
        .clr     (srst),
        .wr_en   (push & ~srst),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (pop & ~srst),
        .rd_addr (rd_ptr),
        .rd_data (dout)
    );

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            data_count  <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (srst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            data_count  <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            data_count  <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == CNT_W'(DEPTH));
            almost_full <= (count_nxt >= CNT_W'(AFULL_THR));
            if (wr_en & full) begin
                overflow <= 1'b1;
            end
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_api_sync_fifo.sv
// Self-checking bench for api_sync_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_api_sync_fifo;

    logic        CLK_I = 1'b0;
    logic        RST_N_I;
    logic        srst;
    logic [31:0] din;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] dout;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic [9:0]  data_count;
    logic        overflow;
    logic        underflow;

    api_sync_fifo dut (
        .CLK_I       (CLK_I),
        .RST_N_I     (RST_N_I),
        .srst        (srst),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .data_count  (data_count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 CLK_I = ~CLK_I;

    int checks = 0;
    int errors = 0;

    // reference model
    logic [31:0] q[$];
    logic [31:0] m_dout;
    logic        m_ovf;
    logic        m_udf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic w, input logic r, input logic [31:0] d);
        bit was_full;
        bit was_empty;
        if (s) begin
            model_reset();
        end else begin
            was_full  = (q.size() == 512);
            was_empty = (q.size() == 0);
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            if (r && !was_empty) m_dout = q.pop_front();
            if (w && !was_full) q.push_back(d);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ":count"}, 32'(data_count), 32'(q.size()));
        chk({tag, ":empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ":full"},  32'(full),  32'(q.size() == 512));
        chk({tag, ":afull"}, 32'(almost_full), 32'(q.size() >= 480));
        chk({tag, ":dout"},  dout, m_dout);
        chk({tag, ":ovf"},   32'(overflow),  32'(m_ovf));
        chk({tag, ":udf"},   32'(underflow), 32'(m_udf));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step(input logic s, input logic w, input logic r, input logic [31:0] d);
        srst  = s;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge CLK_I);
        model_step(s, w, r, d);
        #1;
        srst  = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic async_reset_check();
        #2 RST_N_I = 1'b0;
        #1;
        model_reset();
        chk("async:count", 32'(data_count), 32'd0);
        chk("async:empty", 32'(empty), 32'd1);
        chk("async:full",  32'(full),  32'd0);
        chk("async:dout",  dout, 32'd0);
        @(posedge CLK_I);
        #1 RST_N_I = 1'b1;
        check_model("after_async");
    endtask

    typedef struct {
        logic        s;
        logic        w;
        logic        r;
        logic [31:0] d;
        int          cnt;
        logic        emp;
        logic [31:0] dv;
        logic        udf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_00A1, 1, 1'b0, 32'h0,          1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_00A2, 2, 1'b0, 32'h0,          1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0,         1, 1'b0, 32'h0000_00A1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_00A3, 1, 1'b0, 32'h0000_00A2, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0,         0, 1'b1, 32'h0000_00A3, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0,         0, 1'b1, 32'h0000_00A3, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_00A4, 1, 1'b0, 32'h0000_00A3, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_00A5, 0, 1'b1, 32'h0,          1'b0};

        RST_N_I = 1'b0;
        srst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        model_reset();
        repeat (3) @(posedge CLK_I);
        #1 RST_N_I = 1'b1;
        check_model("reset");

        // table vectors
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].s, vecs[i].w, vecs[i].r, vecs[i].d);
            chk($sformatf("vec%0d:count", i), 32'(data_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d:empty", i), 32'(empty), 32'(vecs[i].emp));
            chk($sformatf("vec%0d:dout", i),  dout, vecs[i].dv);
            chk($sformatf("vec%0d:udf", i),   32'(underflow), 32'(vecs[i].udf));
        end

        // ordered fill to full, then drain
        for (int i = 0; i < 512; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'(i));
            check_model("fill");
        end
        chk("fill:full_count", 32'(data_count), 32'd512);
        chk("fill:full_flag", 32'(full), 32'd1);
        for (int i = 0; i < 512; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            chk("drain:order", dout, 32'(i));
            check_model("drain");
        end
        chk("drain:empty", 32'(empty), 32'd1);

        // full boundary: push with pop
        for (int i = 0; i < 512; i++) step(1'b0, 1'b1, 1'b0, 32'h5000_0000 + 32'(i));
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        chk("full_both:count", 32'(data_count), 32'd511);
        chk("full_both:ovf", 32'(overflow), 32'd1);
        check_model("full_both");
        for (int i = 0; i < 511; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            check_model("full_drain");
        end

        // empty boundary: push with pop
        step(1'b0, 1'b1, 1'b1, 32'h1234_5678);
        chk("empty_both:count", 32'(data_count), 32'd1);
        chk("empty_both:udf", 32'(underflow), 32'd1);
        check_model("empty_both");
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("empty_both:readable", dout, 32'h1234_5678);

        // flush at count 100 with a concurrent push
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 32'h7000_0000 + 32'(i));
        step(1'b1, 1'b1, 1'b0, 32'hFFFF_0000);
        chk("flush:count", 32'(data_count), 32'd0);
        chk("flush:empty", 32'(empty), 32'd1);
        chk("flush:ovf", 32'(overflow), 32'd0);
        chk("flush:udf", 32'(underflow), 32'd0);
        check_model("flush");
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("flush:still_empty", 32'(data_count), 32'd0);

        // steady state at 300
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'hB000_0000 + 32'(i));
            chk("steady:count", 32'(data_count), 32'd300);
            chk("steady:order", dout, 32'hA000_0000 + 32'(i));
            check_model("steady");
        end

        // random traffic with an asynchronous reset mid-run
        for (int i = 0; i < 3000; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            check_model("rand");
            if (i == 1500) async_reset_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
